// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for the shared memory of the accumulator processor.
// Port 0 is instruction fetch, port 1 is load/store; one transaction per IDLE -> ACCESS -> RESPOND pass.
module mem_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  Req0,
  input  logic                  Wr0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  input  logic                  Req1,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic                  Err0,
  output logic                  Err1,
  output logic [DATA_WIDTH-1:0] RData,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemOutput,
  input  logic                  MemOverflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  grant;
  logic                  grant_port;
  logic                  contested;
  logic                  rr_ptr;      // port that wins the next contested grant
  logic                  lat_port;
  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  in_access;
  logic                  in_respond;

  assign contested = Req0 & Req1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 | Req1) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          if (contested) begin
            grant_port = (FIXED_PRIORITY != 0) ? 1'b0 : rr_ptr;
          end else begin
            grant_port = Req1;
          end
        end
      end
      ACCESS:  state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant so requesters may change them afterwards.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr   <= 1'b0;
      lat_port <= 1'b0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (grant) begin
        lat_port <= grant_port;
        lat_wr   <= grant_port ? Wr1    : Wr0;
        lat_addr <= grant_port ? Addr1  : Addr0;
        lat_data <= grant_port ? WData1 : WData0;
        if (contested && (FIXED_PRIORITY == 0)) begin
          rr_ptr <= ~grant_port;
        end
      end
      if (in_access) begin
        ovf_q   <= MemOverflow;
        rdata_q <= (lat_wr | MemOverflow) ? '0 : MemOutput;
      end
    end
  end

  assign in_access  = (state == ACCESS);
  assign in_respond = (state == RESPOND);

  // Write strobe is gated by overflow combinationally so a bad write never lands.
  assign MemAddress = in_access ? lat_addr : '0;
  assign MemData    = in_access ? lat_data : '0;
  assign MemRead    = in_access & ~lat_wr;
  assign MemWrite   = in_access & lat_wr & ~MemOverflow;

  assign Ack0  = in_respond & ~lat_port;
  assign Ack1  = in_respond &  lat_port;
  assign Err0  = in_respond & ~lat_port & ovf_q;
  assign Err1  = in_respond &  lat_port & ovf_q;
  assign RData = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (index 0) and a fixed-priority instance (index 1),
// each with its own 256-word memory; a transaction-level model is compared every cycle.
module tb_mem_arbiter;

  logic        CLK;
  logic        Reset_n;

  logic        req0 [2];
  logic        wr0  [2];
  logic [15:0] addr0 [2];
  logic [15:0] wdata0 [2];
  logic        req1 [2];
  logic        wr1  [2];
  logic [15:0] addr1 [2];
  logic [15:0] wdata1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic        err0 [2];
  logic        err1 [2];
  logic [15:0] rdata [2];
  logic [15:0] maddr [2];
  logic [15:0] mdata [2];
  logic        mwrite [2];
  logic        mread [2];
  logic [15:0] mout [2];
  logic        movf [2];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(0)) dut_rr (
    .CLK(CLK), .Reset_n(Reset_n),
    .Req0(req0[0]), .Wr0(wr0[0]), .Addr0(addr0[0]), .WData0(wdata0[0]),
    .Req1(req1[0]), .Wr1(wr1[0]), .Addr1(addr1[0]), .WData1(wdata1[0]),
    .Ack0(ack0[0]), .Ack1(ack1[0]), .Err0(err0[0]), .Err1(err1[0]),
    .RData(rdata[0]), .MemAddress(maddr[0]), .MemData(mdata[0]),
    .MemWrite(mwrite[0]), .MemRead(mread[0]),
    .MemOutput(mout[0]), .MemOverflow(movf[0])
  );

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(1)) dut_fp (
    .CLK(CLK), .Reset_n(Reset_n),
    .Req0(req0[1]), .Wr0(wr0[1]), .Addr0(addr0[1]), .WData0(wdata0[1]),
    .Req1(req1[1]), .Wr1(wr1[1]), .Addr1(addr1[1]), .WData1(wdata1[1]),
    .Ack0(ack0[1]), .Ack1(ack1[1]), .Err0(err0[1]), .Err1(err1[1]),
    .RData(rdata[1]), .MemAddress(maddr[1]), .MemData(mdata[1]),
    .MemWrite(mwrite[1]), .MemRead(mread[1]),
    .MemOutput(mout[1]), .MemOverflow(movf[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Environment memory: 256 words, unwritten words read as 16'h1000 | address.
  bit [15:0] env_mem   [2][256];
  bit        env_wrote [2][256];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      movf[d] = (maddr[d] >= 16'd256);
      if (maddr[d] >= 16'd256) mout[d] = 16'h0000;
      else if (env_wrote[d][maddr[d][7:0]]) mout[d] = env_mem[d][maddr[d][7:0]];
      else mout[d] = 16'h1000 | {8'h00, maddr[d][7:0]};
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      for (int d = 0; d < 2; d++) begin
        if (mwrite[d] === 1'b1) begin
          env_mem[d][maddr[d][7:0]]   = mdata[d];
          env_wrote[d][maddr[d][7:0]] = 1'b1;
        end
      end
    end
  end

  // Transaction-level model: m_cnt counts cycles left in the current transaction.
  int        m_cnt  [2];
  bit        m_ptr  [2];
  bit        m_port [2];
  bit        m_wr   [2];
  bit [15:0] m_addr [2];
  bit [15:0] m_wd   [2];
  bit [15:0] m_rd   [2];
  bit [15:0] ref_mem   [2][256];
  bit        ref_wrote [2][256];

  function automatic bit [15:0] ref_word(input int d, input bit [15:0] a);
    return ref_wrote[d][a[7:0]] ? ref_mem[d][a[7:0]] : (16'h1000 | {8'h00, a[7:0]});
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!Reset_n) begin
        m_cnt[d] = 0;
        m_ptr[d] = 1'b0;
        m_rd[d]  = 16'h0000;
      end else if (m_cnt[d] == 2) begin
        m_cnt[d] = 1;
        if (m_addr[d] >= 16'd256) begin
          m_rd[d] = 16'h0000;
        end else if (m_wr[d]) begin
          ref_mem[d][m_addr[d][7:0]]   = m_wd[d];
          ref_wrote[d][m_addr[d][7:0]] = 1'b1;
          m_rd[d] = 16'h0000;
        end else begin
          m_rd[d] = ref_word(d, m_addr[d]);
        end
      end else if (m_cnt[d] == 1) begin
        m_cnt[d] = 0;
      end else if (req0[d] || req1[d]) begin
        bit w;
        if (req0[d] && req1[d]) begin
          if (d == 1) begin
            w = 1'b0;
          end else begin
            w = m_ptr[d];
            m_ptr[d] = ~w;
          end
        end else begin
          w = req1[d];
        end
        m_port[d] = w;
        m_wr[d]   = w ? wr1[d]    : wr0[d];
        m_addr[d] = w ? addr1[d]  : addr0[d];
        m_wd[d]   = w ? wdata1[d] : wdata0[d];
        m_cnt[d]  = 2;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge Reset_n);
      model_step();
    end
  end

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      bit acc, rsp, ovf;
      acc = (m_cnt[d] == 2);
      rsp = (m_cnt[d] == 1);
      ovf = (m_addr[d] >= 16'd256);
      check("mem_read",  d, 32'(mread[d]),  32'(acc && !m_wr[d]));
      check("mem_write", d, 32'(mwrite[d]), 32'(acc && m_wr[d] && !ovf));
      if (acc) begin
        check("mem_address", d, 32'(maddr[d]), 32'(m_addr[d]));
        check("mem_data",    d, 32'(mdata[d]), 32'(m_wd[d]));
      end
      check("ack0",  d, 32'(ack0[d]),  32'(rsp && !m_port[d]));
      check("ack1",  d, 32'(ack1[d]),  32'(rsp && m_port[d]));
      check("err0",  d, 32'(err0[d]),  32'(rsp && !m_port[d] && ovf));
      check("err1",  d, 32'(err1[d]),  32'(rsp && m_port[d] && ovf));
      check("rdata", d, 32'(rdata[d]), 32'(m_rd[d]));
      check("one_ack", d, 32'(ack0[d] & ack1[d]), 32'd0);
      check("rd_wr_excl", d, 32'(mread[d] & mwrite[d]), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      compare();
    end
  end

  // One transaction on port p of instance d; reports the ACCESS-cycle strobes and the response.
  task automatic do_txn(input int d, input int p, input bit wr, input bit [15:0] a, input bit [15:0] wd,
                        output bit [15:0] rd, output bit er, output int lat,
                        output bit s_rd, output bit s_wr, output bit [15:0] s_addr);
    @(negedge CLK);
    if (p == 0) begin
      req0[d] = 1'b1; wr0[d] = wr; addr0[d] = a; wdata0[d] = wd;
    end else begin
      req1[d] = 1'b1; wr1[d] = wr; addr1[d] = a; wdata1[d] = wd;
    end
    lat = 0; rd = 16'h0; er = 1'b0; s_rd = 1'b0; s_wr = 1'b0; s_addr = 16'h0;
    while (1) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        s_rd = mread[d]; s_wr = mwrite[d]; s_addr = maddr[d];
      end
      if ((p == 0) ? ack0[d] : ack1[d]) begin
        rd = rdata[d];
        er = (p == 0) ? err0[d] : err1[d];
        break;
      end
      if (lat >= 12) begin
        check("txn_timeout", d, 32'(lat), 32'd2);
        break;
      end
    end
    if (p == 0) req0[d] = 1'b0;
    else        req1[d] = 1'b0;
  endtask

  initial begin
    bit [15:0] rd, s_addr;
    bit        er, s_rd, s_wr;
    int        lat, n;
    int        order [$];
    int        exp_rr [4] = '{0, 1, 0, 1};
    int        exp_fp [4] = '{0, 0, 0, 1};
    int        acks0;

    Reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; wr0[d] = 1'b0; addr0[d] = 16'h0; wdata0[d] = 16'h0;
      req1[d] = 1'b0; wr1[d] = 1'b0; addr1[d] = 16'h0; wdata1[d] = 16'h0;
    end
    repeat (2) @(negedge CLK);
    check("reset_ack0",   0, 32'(ack0[0]),  32'd0);
    check("reset_ack1",   0, 32'(ack1[0]),  32'd0);
    check("reset_rdata",  0, 32'(rdata[0]), 32'd0);
    check("reset_maddr",  0, 32'(maddr[0]), 32'd0);
    check("reset_mdata",  0, 32'(mdata[0]), 32'd0);
    check("reset_strobe", 0, 32'({mread[0], mwrite[0]}), 32'd0);
    Reset_n = 1'b1;

    // Single read on port 0.
    do_txn(0, 0, 1'b0, 16'h0004, 16'h0, rd, er, lat, s_rd, s_wr, s_addr);
    check("read_latency", 0, 32'(lat), 32'd2);
    check("read_memread", 0, 32'(s_rd), 32'd1);
    check("read_addr",    0, 32'(s_addr), 32'h0004);
    check("read_data",    0, 32'(rd), 32'h1004);
    check("read_err",     0, 32'(er), 32'd0);

    // Port 1 write then read-back.
    do_txn(0, 1, 1'b1, 16'h0000, 16'h1145, rd, er, lat, s_rd, s_wr, s_addr);
    check("write_strobe", 0, 32'(s_wr), 32'd1);
    check("write_err",    0, 32'(er), 32'd0);
    check("write_rdata",  0, 32'(rd), 32'd0);
    do_txn(0, 1, 1'b0, 16'h0000, 16'h0, rd, er, lat, s_rd, s_wr, s_addr);
    check("readback", 0, 32'(rd), 32'h1145);

    // Overflowing write on port 1.
    do_txn(0, 1, 1'b1, 16'hFFFF, 16'hBEEF, rd, er, lat, s_rd, s_wr, s_addr);
    check("ovf_memwrite", 0, 32'(s_wr), 32'd0);
    check("ovf_err",      0, 32'(er), 32'd1);
    check("ovf_rdata",    0, 32'(rd), 32'd0);
    check("ovf_mem_kept", 0, 32'(env_wrote[0][255]), 32'd0);

    // Round-robin contention: both held high for four transactions.
    @(negedge CLK);
    req0[0] = 1'b1; wr0[0] = 1'b0; addr0[0] = 16'h0010;
    req1[0] = 1'b1; wr1[0] = 1'b0; addr1[0] = 16'h0020;
    order.delete();
    n = 0;
    while (order.size() < 4 && n < 30) begin
      @(negedge CLK);
      n++;
      if (ack0[0]) order.push_back(0);
      if (ack1[0]) order.push_back(1);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    check("rr_count", 0, 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", 0, 32'(order[i]), 32'(exp_rr[i]));

    // Fixed priority: port 0 wins until it drops after three grants.
    @(negedge CLK);
    req0[1] = 1'b1; wr0[1] = 1'b0; addr0[1] = 16'h0030;
    req1[1] = 1'b1; wr1[1] = 1'b0; addr1[1] = 16'h0040;
    order.delete();
    n = 0;
    acks0 = 0;
    while (order.size() < 4 && n < 40) begin
      @(negedge CLK);
      n++;
      if (ack0[1]) begin
        order.push_back(0);
        acks0++;
        if (acks0 == 3) req0[1] = 1'b0;
      end
      if (ack1[1]) order.push_back(1);
    end
    req0[1] = 1'b0; req1[1] = 1'b0;
    check("fp_count", 1, 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) check("fp_order", 1, 32'(order[i]), 32'(exp_fp[i]));

    // Reset in the middle of an ACCESS cycle.
    @(negedge CLK);
    req0[0] = 1'b1; wr0[0] = 1'b0; addr0[0] = 16'h0008;
    @(posedge CLK);
    #2;
    check("pre_reset_memread", 0, 32'(mread[0]), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("abort_memread", 0, 32'(mread[0]), 32'd0);
    check("abort_maddr",   0, 32'(maddr[0]), 32'd0);
    check("abort_rdata",   0, 32'(rdata[0]), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      check("abort_no_ack", 0, 32'(ack0[0]), 32'd0);
    end
    Reset_n = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge CLK);
      lat++;
      if (ack0[0] || lat >= 12) break;
    end
    rd = rdata[0];
    req0[0] = 1'b0;
    check("post_reset_latency", 0, 32'(lat), 32'd2);
    check("post_reset_data",    0, 32'(rd), 32'h1008);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
